// File: rtl/rgb_ball_pkg.sv
// Shared types and defaults for the RGB ball detector path.
// Colour codes, output-holder state encoding and batch-counter defaults.
package rgb_ball_pkg;

    typedef enum logic [1:0] {
        GC = 2'b00,
        BC = 2'b01,
        RC = 2'b10
    } colour_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } res_state_e;

    localparam int unsigned DEF_BATCH_LEN = 16;
    localparam int unsigned DEF_CNT_W     = 5;

endpackage

// File: rtl/batch_run_tracker.sv
// Tracks the current and longest run of consecutive detections in a batch.
// max_run is combinational and already includes the ball accepted this cycle.
// No backpressure; close/clr restart both counters on the same edge.
module batch_run_tracker
    import rgb_ball_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             vld,
    input  logic             det,
    input  logic             close,
    output logic [CNT_W-1:0] max_run
);

    logic [CNT_W-1:0] cur_q, cur_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [CNT_W-1:0] cur_now;

    always_comb begin
        cur_now = cur_q;
        if (vld) begin
            cur_now = det ? cur_q + 1'b1 : '0;
        end
        max_run = (cur_now > max_q) ? cur_now : max_q;

        cur_d = cur_now;
        max_d = max_run;
        if (clr || close) begin
            cur_d = '0;
            max_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q <= '0;
            max_q <= '0;
        end else begin
            cur_q <= cur_d;
            max_q <= max_d;
        end
    end

endmodule

// File: rtl/rgb_combo_batch_counter.sv
// Batches accepted balls/detections into fixed-length results on a valid/ready port.
// Result valid one cycle after the closing ball/flush; one-entry holder, overflow drops new batch.
// res_vld never depends on res_rdy; BATCH_STREAK_EN adds res_max_run via batch_run_tracker.
module rgb_combo_batch_counter
    import rgb_ball_pkg::*;
#(
    parameter int unsigned BATCH_LEN = DEF_BATCH_LEN,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             det_vld,
    input  logic             det_in,
    input  logic             flush,
    input  logic             clr,
    output logic             res_vld,
    input  logic             res_rdy,
    output logic [CNT_W-1:0] res_ball_cnt,
    output logic [CNT_W-1:0] res_det_cnt,
    output logic             ovf
`ifdef BATCH_STREAK_EN
    ,
    output logic [CNT_W-1:0] res_max_run
`endif
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BATCH_LEN - 1);

    res_state_e       state_q, state_d;
    logic [CNT_W-1:0] ball_cnt_q, ball_cnt_d;
    logic [CNT_W-1:0] det_cnt_q, det_cnt_d;
    logic [CNT_W-1:0] res_ball_q, res_ball_d;
    logic [CNT_W-1:0] res_det_q, res_det_d;
    logic             ovf_q, ovf_d;

    logic [CNT_W-1:0] ball_tot, det_tot;
    logic             close, load;

    always_comb begin
        ball_tot = ball_cnt_q + CNT_W'(det_vld);
        det_tot  = det_cnt_q + CNT_W'(det_vld & det_in);
        // A flush closes only if the batch holds at least one ball, this cycle's included.
        close    = (det_vld && (ball_cnt_q == LAST_IDX)) || (flush && (ball_tot != '0));
        load     = close && ((state_q == EMPTY) || res_rdy);
    end

    always_comb begin
        state_d    = state_q;
        ball_cnt_d = close ? '0 : ball_tot;
        det_cnt_d  = close ? '0 : det_tot;
        res_ball_d = res_ball_q;
        res_det_d  = res_det_q;
        ovf_d      = ovf_q;

        if (clr) begin
            state_d    = EMPTY;
            ball_cnt_d = '0;
            det_cnt_d  = '0;
            res_ball_d = '0;
            res_det_d  = '0;
            ovf_d      = 1'b0;
        end else begin
            if (load) begin
                res_ball_d = ball_tot;
                res_det_d  = det_tot;
            end
            case (state_q)
                EMPTY: if (close) state_d = FULL;
                FULL: begin
                    if (res_rdy && !close) state_d = EMPTY;
                    if (close && !res_rdy) ovf_d = 1'b1;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            ball_cnt_q <= '0;
            det_cnt_q  <= '0;
            res_ball_q <= '0;
            res_det_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ball_cnt_q <= ball_cnt_d;
            det_cnt_q  <= det_cnt_d;
            res_ball_q <= res_ball_d;
            res_det_q  <= res_det_d;
            ovf_q      <= ovf_d;
        end
    end

    assign res_vld      = (state_q == FULL);
    assign res_ball_cnt = res_ball_q;
    assign res_det_cnt  = res_det_q;
    assign ovf          = ovf_q;

`ifdef BATCH_STREAK_EN
    logic [CNT_W-1:0] run_max;
    logic [CNT_W-1:0] res_run_q, res_run_d;

    batch_run_tracker #(
        .CNT_W (CNT_W)
    ) u_run (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .vld     (det_vld),
        .det     (det_in),
        .close   (close),
        .max_run (run_max)
    );

    always_comb begin
        res_run_d = res_run_q;
        if (clr) begin
            res_run_d = '0;
        end else if (load) begin
            res_run_d = run_max;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_run_q <= '0;
        end else begin
            res_run_q <= res_run_d;
        end
    end

    assign res_max_run = res_run_q;
`endif

endmodule

// File: tb/tb_rgb_combo_batch_counter.sv
// Directed self-checking bench for rgb_combo_batch_counter (BATCH_LEN=16, CNT_W=5).
// Inputs change on the falling edge; outputs are checked on the falling edge after the update.
module tb_rgb_combo_batch_counter;

    localparam int BL = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          det_vld = 1'b0;
    logic          det_in = 1'b0;
    logic          flush = 1'b0;
    logic          clr = 1'b0;
    logic          res_rdy = 1'b0;
    logic          res_vld;
    logic [CW-1:0] res_ball_cnt;
    logic [CW-1:0] res_det_cnt;
    logic          ovf;
`ifdef BATCH_STREAK_EN
    logic [CW-1:0] res_max_run;
`endif

    int n_cmp = 0;
    int n_err = 0;

    rgb_combo_batch_counter #(
        .BATCH_LEN (BL),
        .CNT_W     (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .det_vld      (det_vld),
        .det_in       (det_in),
        .flush        (flush),
        .clr          (clr),
        .res_vld      (res_vld),
        .res_rdy      (res_rdy),
        .res_ball_cnt (res_ball_cnt),
        .res_det_cnt  (res_det_cnt),
        .ovf          (ovf)
`ifdef BATCH_STREAK_EN
        ,
        .res_max_run  (res_max_run)
`endif
    );

    always #5 clk = ~clk;

    task automatic idle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ball(input logic d);
        det_vld = 1'b1;
        det_in  = d;
        idle();
        det_vld = 1'b0;
        det_in  = 1'b0;
    endtask

    task automatic drain();
        res_rdy = 1'b1;
        idle();
        res_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (res_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %0b want 0", res_vld); end
        n_cmp++; if (res_ball_cnt !== 5'd0) begin n_err++; $display("FAIL reset_ball: got %0d want 0", res_ball_cnt); end
        n_cmp++; if (res_det_cnt !== 5'd0) begin n_err++; $display("FAIL reset_det: got %0d want 0", res_det_cnt); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
`ifdef BATCH_STREAK_EN
        n_cmp++; if (res_max_run !== 5'd0) begin n_err++; $display("FAIL reset_run: got %0d want 0", res_max_run); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_full_batch();
        logic [15:0] mask;
        mask = 16'h811C;
        for (int i = 0; i < BL - 1; i++) ball(mask[i]);
        n_cmp++; if (res_vld !== 1'b0) begin n_err++; $display("FAIL full_vld_early: got %0b want 0", res_vld); end
        ball(mask[BL-1]);
        n_cmp++; if (res_vld !== 1'b1) begin n_err++; $display("FAIL full_vld: got %0b want 1", res_vld); end
        n_cmp++; if (res_ball_cnt !== 5'd16) begin n_err++; $display("FAIL full_ball: got %0d want 16", res_ball_cnt); end
        n_cmp++; if (res_det_cnt !== 5'd5) begin n_err++; $display("FAIL full_det: got %0d want 5", res_det_cnt); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL full_ovf: got %0b want 0", ovf); end
    endtask

    task automatic test_overflow();
        logic [15:0] mask;
        mask = 16'h0003;
        res_rdy = 1'b0;
        for (int i = 0; i < BL; i++) ball(mask[i]);
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %0b want 1", ovf); end
        n_cmp++; if (res_vld !== 1'b1) begin n_err++; $display("FAIL ovf_vld: got %0b want 1", res_vld); end
        n_cmp++; if (res_det_cnt !== 5'd5) begin n_err++; $display("FAIL ovf_held_det: got %0d want 5", res_det_cnt); end
        drain();
        n_cmp++; if (res_vld !== 1'b0) begin n_err++; $display("FAIL ovf_drain_vld: got %0b want 0", res_vld); end
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %0b want 1", ovf); end
        clr = 1'b1;
        idle();
        clr = 1'b0;
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clr: got %0b want 0", ovf); end
    endtask

    task automatic test_flush();
        logic [6:0] mask;
        mask = 7'b0001001;
        for (int i = 0; i < 7; i++) ball(mask[i]);
        n_cmp++; if (res_vld !== 1'b0) begin n_err++; $display("FAIL flush_pre_vld: got %0b want 0", res_vld); end
        flush = 1'b1;
        idle();
        flush = 1'b0;
        n_cmp++; if (res_vld !== 1'b1) begin n_err++; $display("FAIL flush_vld: got %0b want 1", res_vld); end
        n_cmp++; if (res_ball_cnt !== 5'd7) begin n_err++; $display("FAIL flush_ball: got %0d want 7", res_ball_cnt); end
        n_cmp++; if (res_det_cnt !== 5'd2) begin n_err++; $display("FAIL flush_det: got %0d want 2", res_det_cnt); end
        res_rdy = 1'b1;
        flush   = 1'b1;
        idle();
        res_rdy = 1'b0;
        flush   = 1'b0;
        n_cmp++; if (res_vld !== 1'b0) begin n_err++; $display("FAIL flush_empty_hs: got %0b want 0", res_vld); end
        flush = 1'b1;
        idle();
        flush = 1'b0;
        n_cmp++; if (res_vld !== 1'b0) begin n_err++; $display("FAIL flush_empty: got %0b want 0", res_vld); end
        ball(1'b1);
        ball(1'b0);
        ball(1'b1);
        det_vld = 1'b1;
        det_in  = 1'b1;
        flush   = 1'b1;
        idle();
        det_vld = 1'b0;
        det_in  = 1'b0;
        flush   = 1'b0;
        n_cmp++; if (res_ball_cnt !== 5'd4) begin n_err++; $display("FAIL flush_ball_same_edge: got %0d want 4", res_ball_cnt); end
        n_cmp++; if (res_det_cnt !== 5'd3) begin n_err++; $display("FAIL flush_det_same_edge: got %0d want 3", res_det_cnt); end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [15:0] mask;
        mask = 16'h5555;
        for (int i = 0; i < BL; i++) ball(mask[i]);
        for (int i = 0; i < BL - 1; i++) ball(1'b0);
        n_cmp++; if (res_det_cnt !== 5'd8) begin n_err++; $display("FAIL b2b_held_det: got %0d want 8", res_det_cnt); end
        det_vld = 1'b1;
        det_in  = 1'b1;
        res_rdy = 1'b1;
        idle();
        det_vld = 1'b0;
        det_in  = 1'b0;
        res_rdy = 1'b0;
        n_cmp++; if (res_vld !== 1'b1) begin n_err++; $display("FAIL b2b_vld: got %0b want 1", res_vld); end
        n_cmp++; if (res_ball_cnt !== 5'd16) begin n_err++; $display("FAIL b2b_ball: got %0d want 16", res_ball_cnt); end
        n_cmp++; if (res_det_cnt !== 5'd1) begin n_err++; $display("FAIL b2b_det: got %0d want 1", res_det_cnt); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL b2b_ovf: got %0b want 0", ovf); end
        drain();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < BL; i++) ball(1'b1);
        for (int i = 0; i < 10; i++) ball(1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (res_vld !== 1'b0) begin n_err++; $display("FAIL areset_vld: got %0b want 0", res_vld); end
        n_cmp++; if (res_ball_cnt !== 5'd0) begin n_err++; $display("FAIL areset_ball: got %0d want 0", res_ball_cnt); end
        n_cmp++; if (res_det_cnt !== 5'd0) begin n_err++; $display("FAIL areset_det: got %0d want 0", res_det_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) ball(1'b0);
        n_cmp++; if (res_vld !== 1'b0) begin n_err++; $display("FAIL areset_partial_lost: got %0b want 0", res_vld); end
        for (int i = 0; i < BL - 6; i++) ball(1'b0);
        n_cmp++; if (res_vld !== 1'b1) begin n_err++; $display("FAIL areset_after_vld: got %0b want 1", res_vld); end
        n_cmp++; if (res_ball_cnt !== 5'd16) begin n_err++; $display("FAIL areset_after_ball: got %0d want 16", res_ball_cnt); end
        drain();
    endtask

    task automatic test_clr();
        for (int i = 0; i < 5; i++) ball(1'b1);
        det_vld = 1'b1;
        det_in  = 1'b1;
        clr     = 1'b1;
        idle();
        det_vld = 1'b0;
        det_in  = 1'b0;
        clr     = 1'b0;
        for (int i = 0; i < BL - 1; i++) ball(i < 3);
        n_cmp++; if (res_vld !== 1'b0) begin n_err++; $display("FAIL clr_early_vld: got %0b want 0", res_vld); end
        ball(1'b0);
        n_cmp++; if (res_ball_cnt !== 5'd16) begin n_err++; $display("FAIL clr_ball: got %0d want 16", res_ball_cnt); end
        n_cmp++; if (res_det_cnt !== 5'd3) begin n_err++; $display("FAIL clr_det: got %0d want 3", res_det_cnt); end
`ifdef BATCH_STREAK_EN
        n_cmp++; if (res_max_run !== 5'd3) begin n_err++; $display("FAIL clr_run: got %0d want 3", res_max_run); end
`endif
        drain();
    endtask

`ifdef BATCH_STREAK_EN
    task automatic test_streak();
        logic [15:0] mask;
        mask = 16'hDBB7;
        for (int i = 0; i < BL; i++) ball(mask[i]);
        n_cmp++; if (res_max_run !== 5'd3) begin n_err++; $display("FAIL streak_run: got %0d want 3", res_max_run); end
        n_cmp++; if (res_det_cnt !== 5'd12) begin n_err++; $display("FAIL streak_det: got %0d want 12", res_det_cnt); end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_full_batch();
        test_overflow();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_clr();
`ifdef BATCH_STREAK_EN
        test_streak();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rgb_combo_batch_counter.md
# rgb_combo_batch_counter

Downstream consumer of the RGB ball-combination detector. Each accepted ball carries that detector's `det` flag. The block accumulates balls and detections over fixed-length batches and presents one batch result at a time on a valid/ready interface to the host or logging stage. A single-entry result holder lets the next batch keep counting while the host stalls; a sticky flag records any batch lost to overflow.

## Interface
- `BATCH_LEN`, 16: balls per batch; must be ≥ 2 and < 2**`CNT_W`.
- `CNT_W`, 5: width of all count fields.
- `clk` input 1: single clock; all logic is on the posedge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `det_vld` input 1: one ball is accepted on this edge.
- `det_in` input 1: detector flag for the accepted ball; ignored when `det_vld`=0.
- `flush` input 1: close the current batch early.
- `clr` input 1: synchronous clear of counters, pending result and `ovf`.
- `res_vld` output 1: a batch result is pending.
- `res_rdy` input 1: host accepts the result.
- `res_ball_cnt` output CNT_W: number of balls in the batch.
- `res_det_cnt` output CNT_W: number of balls in the batch with `det_in`=1.
- `ovf` output 1: sticky flag; a completed batch was dropped.
- `res_max_run` output CNT_W: longest consecutive run of `det_in`=1 in the batch. Present only with `BATCH_STREAK_EN`.

## Operation
- Working counters:
  - `ball_cnt` and `det_cnt` increment on each `det_vld` edge.
  - `det_cnt` increments only when `det_in`=1.
- Batch close happens when either condition holds:
  - a ball is accepted and `ball_cnt`+1 == `BATCH_LEN`, or
  - `flush`=1 and the batch is non-empty, counting any ball accepted on the same edge.
- On close:
  - The closing ball is included in the result.
  - The working counters restart at 0 on that same edge.
- `flush` on an empty batch with no ball accepted that cycle is ignored, and no result is produced.
- Output FSM, two states:
  - EMPTY: `res_vld`=0. On close, load the result and go to FULL.
  - FULL: `res_vld`=1 and result fields are held stable.
    - Handshake (`res_rdy`=1) with no close on the same edge: go to EMPTY.
    - Handshake and close on the same edge: load the new result and stay FULL. `ovf` is not set.
    - Close without handshake: drop the new result, set `ovf`, leave the held result unchanged, stay FULL.
- `clr` has priority over all other inputs. On a `clr` edge:
  - counters go to 0, the FSM goes to EMPTY, `ovf` goes to 0;
  - a ball or `flush` on the same edge is discarded.
- `ovf` clears only by `clr` or reset.

## Timing
- Reset: `res_vld`=0, `res_ball_cnt`=0, `res_det_cnt`=0, `ovf`=0, `res_max_run`=0, internal counters 0, FSM EMPTY. Reset takes effect asynchronously, mid-batch included, and any partial batch is lost.
- `res_vld` rises on the edge that samples the closing ball or `flush`, i.e. one cycle of latency.
- Result fields are registered, and change only on load or reset/`clr`.
- `res_vld` does not depend combinationally on `res_rdy`.
- Full throughput: one ball per clock is sustained indefinitely.

## Configuration
- `BATCH_STREAK_EN` defined:
  - adds the `res_max_run` port and a run tracker;
  - the current run resets on `det_in`=0 and at batch close;
  - the maximum is captured into the result on close, subject to the same drop/hold rules as the counts.
- `BATCH_STREAK_EN` undefined:
  - the port and logic are absent;
  - all other behaviour is identical.

## Structure
- Shared package `rgb_ball_pkg`:
  - colour codes GC=2'b00, BC=2'b01, RC=2'b10;
  - output-FSM state encoding EMPTY/FULL;
  - default `BATCH_LEN`/`CNT_W` constants.
- Sub-module `batch_run_tracker` contains the current-run and max-run counters with close/clear inputs. It is instantiated only under `BATCH_STREAK_EN`.

## Test plan
- Reset, then 16 consecutive balls with `det_in`=1 on balls 3,4,5,9,16 → one cycle after ball 16, `res_vld`=1, `res_ball_cnt`=16, `res_det_cnt`=5, `ovf`=0.
- `res_rdy`=0, run two full batches (5 then 2 detections) → after the second, `ovf`=1, held result still `res_det_cnt`=5; raising `res_rdy` drains it, then `res_vld`=0.
- 7 balls (2 detections), then `flush` → `res_ball_cnt`=7, `res_det_cnt`=2. An immediate second `flush` with no balls → `res_vld` stays 0.
- Result pending, `res_rdy`=1 on the same edge as the 16th ball of the next batch → `res_vld` stays 1, new counts appear next cycle, `ovf`=0.
- Assert `rst_n`=0 asynchronously after ball 10 → all outputs 0 immediately. After release, 16 more balls produce `res_ball_cnt`=16.
- With `BATCH_STREAK_EN`, `det_in` pattern 1,1,1,0,1,1,0,... over 16 balls → `res_max_run`=3; `clr` mid-batch → next result counts only post-`clr` balls.
